lpsa_mult_scheduler: RTL and testbench
======================================

Name: lpsa_mult_scheduler

Overview:
Shares one 8x8 LPSA approximate multiplier datapath between NREQ requesters. Arbitration is round-robin. Each request carries its own accuracy level, which the block turns into the 7-bit per-column carry-mask vector for the final CMA adder row.
The block drives the multiplier operands and mask, waits a fixed latency, captures the 16-bit product and returns it with the requester ID over a valid/ready response channel. It sits between the client-side request logic and the combinational or pipelined multiplier instance.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester ID width (must be >= clog2(NREQ))
MUL_LAT, 1, cycles from operands driven to product valid on mul_result (1..15)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept (one-hot or zero)
req_a  input  8*NREQ  multiplicand; requester i in bits [8i+7:8i]
req_b  input  8*NREQ  multiplier; requester i in bits [8i+7:8i]
req_acc  input  3*NREQ  accuracy level 0..7; requester i in bits [3i+2:3i]
mul_a  output  8  operand A to shared multiplier
mul_b  output  8  operand B to shared multiplier
mul_maskb  output  7  per-column CMA mask to multiplier
mul_result  input  16  product from multiplier
rsp_valid  output  1  response valid
rsp_ready  input  1  response accept
rsp_id  output  IDW  index of the requester served
rsp_result  output  16  captured product

Behaviour:
- Reset, applied on the clock edge: state=IDLE, rr_ptr=0, op regs (a, b, acc)=0, cnt=0, rsp_id=0, rsp_result=0.
- Reset state of outputs: rsp_valid=0, req_ready=0, mul_a=0, mul_b=0, mul_maskb=0.
- Reset mid-operation abandons the in-flight op. No response is produced for it.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - grant = first requester with req_valid set, searching from rr_ptr upward and wrapping modulo NREQ.
  - req_ready[grant]=1 combinationally in this cycle only. All other req_ready bits are 0.
  - On the edge: latch req_a/req_b/req_acc of the grant, set rsp_id=grant, rr_ptr=(grant+1) mod NREQ, cnt=MUL_LAT, go to WAIT.
  - If no req_valid is set, stay in IDLE and leave rr_ptr unchanged.
- req_ready is 0 in WAIT and RESP. A requester holds req_valid and its operands until accepted.
- WAIT:
  - mul_a/mul_b/mul_maskb are driven from the op regs, stable for the whole WAIT.
  - cnt decrements each cycle.
  - In the cycle where cnt==1, capture mul_result into rsp_result and go to RESP.
- RESP:
  - rsp_valid=1; rsp_id and rsp_result are held stable until rsp_ready=1.
  - On handshake go to IDLE. No grant is issued in the handshake cycle.
- Operand outputs hold their last values outside WAIT. They are 0 only after reset.
- Mask mapping: mul_maskb[i] = (i < acc) for i=0..6.
  - acc=0 gives all zeros (fully approximate).
  - acc=7 gives 7'h7F (all CMA columns unmasked, maximum accuracy).
- Latency: request accepted at cycle T → rsp_valid first asserted at T+MUL_LAT+1.
- Peak throughput: one op per MUL_LAT+2 cycles when rsp_ready is held high.
- Fairness: a continuously requesting port waits at most NREQ-1 grants.
- Boundary cases:
  - All requesters valid → strict rotation 0,1,...,NREQ-1,0.
  - Single requester valid → served back-to-back.
  - A request that deasserts before being granted is simply never served; no error is raised.
  - rsp_ready held low → block stalls in RESP and accepts nothing.

Optional Feature:
LPSA_SCHED_STATS_EN
- Defined: adds two output ports:
  - stat_ops (16): count of completed responses.
  - stat_approx (16): count of completed responses with acc<7.
  - Both increment on the rsp handshake, saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and their counters do not exist. Core behaviour is identical.

Decomposition:
- Package lpsa_sched_pkg holds:
  - state enum (IDLE/WAIT/RESP);
  - ACC_W=3, MASK_W=7, OP_W=8, RES_W=16;
  - function acc_to_maskb.
- One sub-module, lpsa_rr_arbiter: NREQ-wide request vector and pointer in; one-hot grant and binary index out; purely combinational.
- The pointer register lives in the scheduler.

Test Plan:
Bench drives mul_result from a stub with MUL_LAT delay, mul_result = {mul_a, mul_b} (traceable).
1. Reset: rst=1 for 2 cycles → rsp_valid=0, req_ready=0, mul_maskb=0; after release with no req_valid, the block stays idle for 10 cycles.
2. Single request: req0 a=8'h12, b=8'h34, acc=3 at T, MUL_LAT=1 →
   - req_ready[0]=1 at T;
   - mul_maskb=7'h07 at T+1;
   - rsp_valid at T+2 with rsp_id=0, rsp_result=16'h1234.
3. All 4 valid continuously with rsp_ready=1 → rsp_id sequence 0,1,2,3,0; each response 3 cycles apart.
4. Backpressure: rsp_ready=0 for 5 cycles while req1 is pending → rsp held stable, req_ready stays 0; req1 is granted the cycle after the handshake completes.
5. acc=7 on req2 → mul_maskb=7'h7F. acc=0 → 7'h00.
6. Reset asserted in WAIT with MUL_LAT=4 → no response appears; rr_ptr=0, so req0 wins the next contention.

Source files
------------

// File: rtl/lpsa_sched_pkg.sv
// Shared types, widths and the accuracy-to-mask helper for the LPSA multiplier scheduler.
package lpsa_sched_pkg;

  localparam int ACC_W  = 3;
  localparam int MASK_W = 7;
  localparam int OP_W   = 8;
  localparam int RES_W  = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Column i of the final CMA row keeps its carry when i < acc; acc=7 unmasks every column.
  function automatic logic [MASK_W-1:0] acc_to_maskb(input logic [ACC_W-1:0] acc);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W; i++) begin
      m[i] = (ACC_W'(i) < acc);
    end
    return m;
  endfunction

endpackage

// File: rtl/lpsa_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requester at or above ptr wins, else lowest overall.
module lpsa_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);

  logic [IDW-1:0] hi_idx;
  logic [IDW-1:0] lo_idx;
  logic           hi_found;
  logic           lo_found;

  // Scanning downward lets the last hit be the lowest index in each region.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_idx   = IDW'(j);
        lo_found = 1'b1;
        if (j >= int'(ptr)) begin
          hi_idx   = IDW'(j);
          hi_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_any = lo_found;
    gnt_idx = hi_found ? hi_idx : lo_idx;
    gnt_oh  = lo_found ? (NREQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/lpsa_mult_scheduler.sv
// Time-shares one LPSA 8x8 approximate multiplier between NREQ round-robin requesters.
// Optional LPSA_SCHED_STATS_EN adds saturating completed/approximate response counters.
module lpsa_mult_scheduler
  import lpsa_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int MUL_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [OP_W*NREQ-1:0]   req_a,
  input  logic [OP_W*NREQ-1:0]   req_b,
  input  logic [ACC_W*NREQ-1:0]  req_acc,
  output logic [OP_W-1:0]        mul_a,
  output logic [OP_W-1:0]        mul_b,
  output logic [MASK_W-1:0]      mul_maskb,
  input  logic [RES_W-1:0]       mul_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [RES_W-1:0]       rsp_result
`ifdef LPSA_SCHED_STATS_EN
  ,
  output logic [15:0]            stat_ops,
  output logic [15:0]            stat_approx
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Requesters hold valid and operands until their ready bit; rsp_* stay stable until rsp_ready.

  state_e               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [OP_W-1:0]      a_q, a_d;
  logic [OP_W-1:0]      b_q, b_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [RES_W-1:0]     res_q, res_d;

  logic [NREQ-1:0]      gnt_oh;
  logic [IDW-1:0]       gnt_idx;
  logic                 gnt_any;
  logic [OP_W-1:0]      sel_a;
  logic [OP_W-1:0]      sel_b;
  logic [ACC_W-1:0]     sel_acc;

  lpsa_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_acc = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (gnt_oh[j]) begin
        sel_a   = req_a[j*OP_W +: OP_W];
        sel_b   = req_b[j*OP_W +: OP_W];
        sel_acc = req_acc[j*ACC_W +: ACC_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    res_d     = res_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          // Nothing is offered while reset is held, so ready stays low then too.
          req_ready = gnt_oh & {NREQ{~rst}};
          a_d       = sel_a;
          b_d       = sel_b;
          acc_d     = sel_acc;
          id_d      = gnt_idx;
          ptr_d     = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
          cnt_d     = CNT_W'(MUL_LAT);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          res_d   = mul_result;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      res_q   <= res_d;
    end
  end

  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign mul_maskb  = acc_to_maskb(acc_q);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;

`ifdef LPSA_SCHED_STATS_EN
  logic [15:0] ops_q, ops_d;
  logic [15:0] apx_q, apx_d;

  always_comb begin
    ops_d = ops_q;
    apx_d = apx_q;
    if ((state_q == RESP) && rsp_ready) begin
      if (ops_q != 16'hFFFF) ops_d = ops_q + 16'd1;
      if ((acc_q != 3'd7) && (apx_q != 16'hFFFF)) apx_d = apx_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_q <= '0;
      apx_q <= '0;
    end else begin
      ops_q <= ops_d;
      apx_q <= apx_d;
    end
  end

  assign stat_ops    = ops_q;
  assign stat_approx = apx_q;
`endif

endmodule

// File: tb/tb_lpsa_mult_scheduler.sv
// Directed bench: one scheduler with a combinational multiplier stub, one with a 4-cycle stub.
module tb_lpsa_mult_scheduler;

  logic        clk = 1'b0;
  logic        rst;

  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [11:0] req_acc;
  logic [7:0]  mul_a, mul_b;
  logic [6:0]  mul_maskb;
  logic [15:0] mul_result;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_result;

  logic [3:0]  req_valid4, req_ready4;
  logic [31:0] req_a4, req_b4;
  logic [11:0] req_acc4;
  logic [7:0]  mul_a4, mul_b4;
  logic [6:0]  mul_maskb4;
  logic [15:0] mul_result4;
  logic        rsp_valid4, rsp_ready4;
  logic [1:0]  rsp_id4;
  logic [15:0] rsp_result4;
  logic [15:0] p4_0, p4_1, p4_2;

`ifdef LPSA_SCHED_STATS_EN
  logic [15:0] stat_ops, stat_approx, stat_ops4, stat_approx4;
`endif

  int vectors = 0;
  int miscompares = 0;

  initial forever #5 clk = ~clk;

  // Multiplier stubs: product is the concatenated operands so results trace back to requesters.
  assign mul_result = {mul_a, mul_b};
  always @(posedge clk) begin
    p4_0 <= {mul_a4, mul_b4};
    p4_1 <= p4_0;
    p4_2 <= p4_1;
  end
  assign mul_result4 = p4_2;

  lpsa_mult_scheduler #(.NREQ(4), .IDW(2), .MUL_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_acc(req_acc),
    .mul_a(mul_a), .mul_b(mul_b), .mul_maskb(mul_maskb), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result)
`ifdef LPSA_SCHED_STATS_EN
    , .stat_ops(stat_ops), .stat_approx(stat_approx)
`endif
  );

  lpsa_mult_scheduler #(.NREQ(4), .IDW(2), .MUL_LAT(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid4), .req_ready(req_ready4),
    .req_a(req_a4), .req_b(req_b4), .req_acc(req_acc4),
    .mul_a(mul_a4), .mul_b(mul_b4), .mul_maskb(mul_maskb4), .mul_result(mul_result4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_id(rsp_id4), .rsp_result(rsp_result4)
`ifdef LPSA_SCHED_STATS_EN
    , .stat_ops(stat_ops4), .stat_approx(stat_approx4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2ns after the rising edge; outputs are sampled 3ns later, mid-cycle.
  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] acc);
    req_a[8*i +: 8]   = a;
    req_b[8*i +: 8]   = b;
    req_acc[3*i +: 3] = acc;
  endtask

  task automatic set_req4(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] acc);
    req_a4[8*i +: 8]   = a;
    req_b4[8*i +: 8]   = b;
    req_acc4[3*i +: 3] = acc;
  endtask

  logic [7:0] t3_a [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
  logic [7:0] t3_b [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
  logic [6:0] t3_m [4] = '{7'h00, 7'h01, 7'h03, 7'h07};

  initial begin
    rst = 1'b1;
    req_valid = 4'hF; req_a = '0; req_b = '0; req_acc = '0; rsp_ready = 1'b1;
    req_valid4 = 4'h0; req_a4 = '0; req_b4 = '0; req_acc4 = '0; rsp_ready4 = 1'b1;

    // 1. reset for two edges, then ten idle cycles
    next(); #3;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_maskb", 32'(mul_maskb), 32'h0);
    chk("rst_mul_a", 32'(mul_a), 32'h0);
    chk("rst_rsp_valid4", 32'(rsp_valid4), 32'h0);
    next(); rst = 1'b0; req_valid = 4'h0;
    for (int k = 0; k < 10; k++) begin
      next(); #3;
      chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("idle_req_ready", 32'(req_ready), 32'h0);
    end

    // 2. single request, MUL_LAT=1
    next(); set_req(0, 8'h12, 8'h34, 3'd3); req_valid = 4'b0001; #3;
    chk("t2_ready", 32'(req_ready), 32'h1);
    next(); req_valid = 4'b0000; #3;
    chk("t2_maskb", 32'(mul_maskb), 32'h07);
    chk("t2_mul_a", 32'(mul_a), 32'h12);
    chk("t2_mul_b", 32'(mul_b), 32'h34);
    chk("t2_no_rsp_yet", 32'(rsp_valid), 32'h0);
    next(); #3;
    chk("t2_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t2_rsp_id", 32'(rsp_id), 32'h0);
    chk("t2_rsp_result", 32'(rsp_result), 32'h1234);

    // reset to bring the pointer back to 0; operand regs clear
    next(); rst = 1'b1;
    next(); rst = 1'b0; #3;
    chk("rerst_mul_a", 32'(mul_a), 32'h0);

    // 3. all four valid continuously: rotation 0,1,2,3,0, one response every 3 cycles
    for (int i = 0; i < 4; i++) set_req(i, t3_a[i], t3_b[i], 3'(i));
    for (int g = 0; g < 5; g++) begin
      next(); if (g == 0) req_valid = 4'hF; #3;
      chk("t3_ready", 32'(req_ready), 32'(4'b0001 << (g % 4)));
      chk("t3_idle_rsp", 32'(rsp_valid), 32'h0);
      next(); #3;
      chk("t3_wait_ready", 32'(req_ready), 32'h0);
      chk("t3_wait_rsp", 32'(rsp_valid), 32'h0);
      chk("t3_maskb", 32'(mul_maskb), 32'(t3_m[g % 4]));
      next(); if (g == 4) req_valid = 4'h0; #3;
      chk("t3_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t3_rsp_id", 32'(rsp_id), 32'(g % 4));
      chk("t3_rsp_result", 32'(rsp_result), 32'({t3_a[g % 4], t3_b[g % 4]}));
    end

    // 4. backpressure: pointer is 1, req0 alone wraps around and wins; req1 waits behind it
    next(); set_req(0, 8'h55, 8'h66, 3'd2); req_valid = 4'b0001; rsp_ready = 1'b0; #3;
    chk("t4_ready0", 32'(req_ready), 32'h1);
    next(); set_req(1, 8'h56, 8'h78, 3'd5); req_valid = 4'b0010; #3;
    chk("t4_wait_ready", 32'(req_ready), 32'h0);
    for (int k = 0; k < 5; k++) begin
      next(); #3;
      chk("t4_stall_valid", 32'(rsp_valid), 32'h1);
      chk("t4_stall_id", 32'(rsp_id), 32'h0);
      chk("t4_stall_result", 32'(rsp_result), 32'h5566);
      chk("t4_stall_ready", 32'(req_ready), 32'h0);
    end
    next(); rsp_ready = 1'b1; #3;
    chk("t4_hs_valid", 32'(rsp_valid), 32'h1);
    chk("t4_hs_no_grant", 32'(req_ready), 32'h0);
    next(); #3;
    chk("t4_ready1", 32'(req_ready), 32'h2);
    chk("t4_idle_rsp", 32'(rsp_valid), 32'h0);
    next(); req_valid = 4'b0000; #3;
    chk("t4_maskb", 32'(mul_maskb), 32'h1F);
    next(); #3;
    chk("t4_rsp_id", 32'(rsp_id), 32'h1);
    chk("t4_rsp_result", 32'(rsp_result), 32'h5678);

    // 5. acc=7 on req2, then acc=0 on req3 served back-to-back
    next(); set_req(2, 8'h9A, 8'hBC, 3'd7); req_valid = 4'b0100; #3;
    chk("t5_ready2", 32'(req_ready), 32'h4);
    next(); req_valid = 4'b0000; #3;
    chk("t5_maskb_7f", 32'(mul_maskb), 32'h7F);
    next(); #3;
    chk("t5_rsp_id2", 32'(rsp_id), 32'h2);
    chk("t5_rsp_res2", 32'(rsp_result), 32'h9ABC);
    next(); set_req(3, 8'hDE, 8'hF0, 3'd0); req_valid = 4'b1000; #3;
    chk("t5_ready3a", 32'(req_ready), 32'h8);
    next(); #3;
    chk("t5_maskb_00", 32'(mul_maskb), 32'h00);
    next(); #3;
    chk("t5_rsp_res3a", 32'(rsp_result), 32'hDEF0);
    next(); set_req(3, 8'h11, 8'h22, 3'd0); #3;
    chk("t5_ready3b", 32'(req_ready), 32'h8);
    next(); req_valid = 4'b0000; #3;
    chk("t5_mul_b3b", 32'(mul_b), 32'h22);
    next(); #3;
    chk("t5_rsp_id3b", 32'(rsp_id), 32'h3);
    chk("t5_rsp_res3b", 32'(rsp_result), 32'h1122);
    next(); #3;
    chk("t5_hold_mul_a", 32'(mul_a), 32'h11);
    chk("t5_after_rsp", 32'(rsp_valid), 32'h0);

`ifdef LPSA_SCHED_STATS_EN
    chk("stat_ops", 32'(stat_ops), 32'd10);
    chk("stat_approx", 32'(stat_approx), 32'd9);
`endif

    // 6. MUL_LAT=4: reset in WAIT abandons the op and returns the pointer to 0
    next(); set_req4(1, 8'h33, 8'h44, 3'd4); req_valid4 = 4'b0010; #3;
    chk("t6_ready1", 32'(req_ready4), 32'h2);
    next(); req_valid4 = 4'b0000; #3;
    chk("t6_maskb", 32'(mul_maskb4), 32'h0F);
    next(); rst = 1'b1; #3;
    chk("t6_wait_rsp", 32'(rsp_valid4), 32'h0);
    next(); rst = 1'b0; #3;
    chk("t6_rst_mul_a", 32'(mul_a4), 32'h0);
    for (int k = 0; k < 8; k++) begin
      next(); #3;
      chk("t6_no_rsp", 32'(rsp_valid4), 32'h0);
    end
    next();
    for (int i = 0; i < 4; i++) set_req4(i, 8'(8'h61 + i), 8'(8'h71 + i), 3'(7 - i));
    req_valid4 = 4'hF; #3;
    chk("t6_ready0", 32'(req_ready4), 32'h1);
    next(); req_valid4 = 4'h0; #3;
    chk("t6_maskb7f", 32'(mul_maskb4), 32'h7F);
    for (int k = 0; k < 3; k++) begin
      next(); #3;
      chk("t6_lat_wait", 32'(rsp_valid4), 32'h0);
    end
    next(); #3;
    chk("t6_rsp_valid", 32'(rsp_valid4), 32'h1);
    chk("t6_rsp_id", 32'(rsp_id4), 32'h0);
    chk("t6_rsp_result", 32'(rsp_result4), 32'h6171);
    next(); #3;
    chk("t6_rsp_done", 32'(rsp_valid4), 32'h0);

`ifdef LPSA_SCHED_STATS_EN
    chk("stat_ops4", 32'(stat_ops4), 32'd1);
    chk("stat_approx4", 32'(stat_approx4), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
